// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state type and oversampling constants.
// Build option: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;  // ticks per serial bit
  localparam int unsigned MID_SAMPLE = 7;   // start-bit sample tick
  localparam int unsigned TICK_W     = 4;   // holds 0..OVERSAMPLE-1

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd3
`endif
  } state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word fall-through head; power-of-two depth.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  // A pop on a full FIFO frees the slot the same cycle, so push may proceed.
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_o || do_pop_c);
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap modulo DEPTH; occupancy tracks accepted pushes and pops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 16x oversampling, configurable frame, receive FIFO, sticky errors.
// Build option: define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 27,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          parity_err
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  logic                 sync1_q, sync2_q, rx_prev_q;
  logic [BAUD_W-1:0]    baud_cnt_q;
  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 busy_q;
  logic                 frame_err_q, overrun_err_q;
  logic                 tick_c, fall_c, mid_c;
  logic                 push_c, frame_set_c, overrun_set_c;
  logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q;
  logic                 parity_set_c;
`endif

  assign tick_c = (baud_cnt_q == BAUD_W'(BAUD_DIV - 1));
  assign fall_c = rx_prev_q && !sync2_q;
  assign mid_c  = tick_c && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

  // Line synchronizer, edge history and free-running oversample divider.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      baud_cnt_q <= '0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      baud_cnt_q <= tick_c ? '0 : baud_cnt_q + BAUD_W'(1);
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // Frame sequencing: start qualification, bit sampling, stop check.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set_c = 1'b0;
`endif
    if (state_q != IDLE && tick_c) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (tick_c && tick_cnt_q == TICK_W'(MID_SAMPLE)) begin
          tick_cnt_d = '0;
          state_d    = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mid_c) begin
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_c) begin
          parity_set_c = (^shift_q) ^ sync2_q ^ PARITY_ODD;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_c) begin
          if (!sync2_q) begin
            frame_set_c = 1'b1;
            state_d     = IDLE;
          end else if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun_set_c = push_c && fifo_full && !(rd_en && !fifo_empty);

  // Sticky error flags; a set event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (frame_set_c)        frame_err_q   <= 1'b1;
      else if (err_clr)       frame_err_q   <= 1'b0;
      if (overrun_set_c)      overrun_err_q <= 1'b1;
      else if (err_clr)       overrun_err_q <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity flag; the word is still delivered on mismatch.
  always_ff @(posedge clk) begin
    if (!rst)              parity_err_q <= 1'b0;
    else if (parity_set_c) parity_err_q <= 1'b1;
    else if (err_clr)      parity_err_q <= 1'b0;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .wdata_i (shift_q),
    .pop_i   (rd_en),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rd_valid    = !fifo_empty;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param with a frame-level reference model.
module tb_uart_rx_param;

  localparam int unsigned BAUD_DIV   = 4;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned BIT_CLKS   = 16 * BAUD_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR_BITS   = 1;
`else
  localparam int unsigned PAR_BITS   = 0;
`endif
  // Final stop mid-sample: 8 ticks into start, then 16 ticks per later bit.
  localparam int unsigned STOP_SAMPLE_CLKS = (8 + 16 * (DATA_BITS + PAR_BITS + 1)) * BAUD_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       busy, frame_err, overrun_err, parity_err;

  always #5 clk = ~clk;

  uart_rx_param #(
    .BAUD_DIV   (BAUD_DIV),
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD (1'b0)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .err_clr     (err_clr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  // Reference model state
  logic [7:0] exp_q[$];
  bit         exp_fe, exp_oe, exp_pe;
  bit         chk_en = 1'b1;
  int         n_checks = 0;
  int         n_errors = 0;

  // Observation of the busy falling edge
  int         cyc = 0;
  int         start_cyc = 0;
  int         fall_cyc = -1;
  logic       busy_prev = 1'b0;
  logic       rv_prev = 1'b0;
  logic       valid_at_fall = 1'b0;
  logic       valid_before_fall = 1'b0;
  logic       busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model while the receiver is quiet.
  always @(negedge clk) begin
    cyc++;
    if (busy_prev && !busy) begin
      fall_cyc          = cyc;
      valid_at_fall     = rd_valid;
      valid_before_fall = rv_prev;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    busy_prev = busy;
    rv_prev   = rd_valid;
    if (chk_en) begin
      check("rd_valid",    32'(rd_valid),    32'(exp_q.size() != 0));
      check("fifo_count",  32'(fifo_count),  32'(exp_q.size()));
      check("rd_data",     32'(rd_data),     (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      check("busy",        32'(busy),        32'd0);
      check("frame_err",   32'(frame_err),   32'(exp_fe));
      check("overrun_err", 32'(overrun_err), 32'(exp_oe));
      check("parity_err",  32'(parity_err),  32'(exp_pe));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one complete frame, then apply its effect to the model.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit bad_par);
    chk_en    = 1'b0;
    start_cyc = cyc;
    rxd = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < DATA_BITS; i++) begin
      rxd = d[i];
      step(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ bad_par;
    step(BIT_CLKS);
    if (bad_par) exp_pe = 1'b1;
`endif
    rxd = stop_b;
    step(BIT_CLKS);
    rxd = 1'b1;
    if (!stop_b) exp_fe = 1'b1;
    else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
    else exp_oe = 1'b1;
    chk_en = 1'b1;
    step(16);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    step(2);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    exp_fe = 1'b0;
    exp_oe = 1'b0;
    exp_pe = 1'b0;
    step(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    // Reset state
    step(4);
    rst = 1'b1;
    step(8);

    // 0xA5 8N1: push lands as busy drops, one clk after the stop sample
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_rd_data",        32'(rd_data),    32'hA5);
    check("a5_rd_valid",       32'(rd_valid),   32'd1);
    check("a5_fifo_count",     32'(fifo_count), 32'd1);
    check("a5_valid_before",   32'(valid_before_fall), 32'd0);
    check("a5_valid_at_idle",  32'(valid_at_fall),     32'd1);
    d = fall_cyc - start_cyc;
    check("a5_stop_sample_time",
          32'(d >= int'(STOP_SAMPLE_CLKS) && d <= int'(STOP_SAMPLE_CLKS) + 8), 32'd1);
    pop();
    check("a5_popped_count", 32'(fifo_count), 32'd0);

    // Start-bit glitch of 5 ticks is rejected
    chk_en    = 1'b0;
    busy_seen = 1'b0;
    rxd = 1'b0;
    step(5 * BAUD_DIV);
    rxd = 1'b1;
    step(BIT_CLKS);
    check("glitch_entered_start", 32'(busy_seen), 32'd1);
    chk_en = 1'b1;
    step(8);
    check("glitch_no_push", 32'(fifo_count), 32'd0);
    check("glitch_no_flag", 32'({frame_err, overrun_err, parity_err}), 32'd0);

    // Bad stop bit: frame error, word discarded, cleared by err_clr
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_set",   32'(frame_err),  32'd1);
    check("ferr_count", 32'(fifo_count), 32'd0);
    clear_errors();
    check("ferr_clear", 32'(frame_err),  32'd0);

    // Nine frames into an eight-entry FIFO
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("ovr_count", 32'(fifo_count),  32'd8);
    check("ovr_flag",  32'(overrun_err), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("ovr_pop_data", 32'(rd_data), 32'(i));
      pop();
    end
    check("ovr_empty", 32'(rd_valid), 32'd0);
    pop();  // pop while empty is ignored
    check("empty_pop_count", 32'(fifo_count), 32'd0);
    clear_errors();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1, send 0
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_flag",  32'(parity_err), 32'd1);
    check("par_data",  32'(rd_data),    32'h07);
    check("par_count", 32'(fifo_count), 32'd1);
    pop();
    clear_errors();
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_good_flag", 32'(parity_err), 32'd0);
    pop();
`else
    check("par_tied_low", 32'(parity_err), 32'd0);
`endif

    // Reset during DATA abandons the frame and clears everything
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    chk_en = 1'b0;
    rxd = 1'b0;
    step(BIT_CLKS);
    rxd = 1'b0;
    step(BIT_CLKS);
    rxd = 1'b1;
    step(BIT_CLKS / 2);
    check("rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    step(1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_flags", 32'({frame_err, overrun_err, parity_err}), 32'd0);
    check("rst_data",  32'(rd_data),    32'd0);
    rst = 1'b1;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_oe = 1'b0;
    exp_pe = 1'b0;
    chk_en = 1'b1;
    step(2 * BIT_CLKS);

    // Receiver resumes after reset
    send_frame(8'hC3, 1'b1, 1'b0);
    check("post_rst_data", 32'(rd_data), 32'hC3);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
